sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 125 ++++++++++++
 tb/tb_sram_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: request/response front end for a 128x32 pulse-protocol SRAM.
// Optional SRAM_CTRL_ADDR_CHECK_EN rejects out-of-range or unaligned addresses.
module sram_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [6:0]  sram_addr,
    output logic        sram_addr_ready,
    output logic        sram_read_pulse,
    output logic        sram_write_pulse,
    output logic [31:0] sram_datain,
    input  logic [31:0] sram_dataout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_PULSE   = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    localparam logic [2:0] S_ERR     = 3'd5;
`endif

    logic [2:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [6:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic accept;
    logic addr_bad;
    logic active;

    // A request presented during reset must not see a ready.
    assign req_ready = (state_q == S_IDLE) && !rst;
    assign accept    = req_ready && req_valid;

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    assign addr_bad = (|req_addr[31:9]) || (|req_addr[1:0]);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:9], req_addr[1:0]};
    assign addr_bad = 1'b0;
`endif

    // Next-state and capture logic for the five-phase access sequence.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr[8:2];
                    wdata_d = req_we ? req_wdata : 32'd0;
                    rdata_d = 32'd0;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
                    state_d = addr_bad ? S_ERR : S_SETUP;
`else
                    state_d = S_SETUP;
`endif
                end
            end
            S_SETUP:   state_d = S_PULSE;
            S_PULSE:   state_d = S_HOLD;
            S_HOLD: begin
                rdata_d = we_q ? 32'd0 : sram_dataout;
                state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
            S_ERR:     state_d = S_IDLE;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    // State and captured-request registers; reset discards any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 7'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Address and data are held from SETUP through RELEASE.
    assign active = (state_q == S_SETUP) || (state_q == S_PULSE) ||
                    (state_q == S_HOLD)  || (state_q == S_RELEASE);

    assign sram_addr        = active ? addr_q  : 7'd0;
    assign sram_datain      = active ? wdata_q : 32'd0;
    assign sram_addr_ready  = (state_q == S_SETUP) || (state_q == S_PULSE) ||
                              (state_q == S_HOLD);
    assign sram_write_pulse = (state_q == S_PULSE) && we_q;
    assign sram_read_pulse  = (state_q == S_PULSE) && !we_q;

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    assign rsp_valid = (state_q == S_RELEASE) || (state_q == S_ERR);
    assign rsp_err   = (state_q == S_ERR);
`else
    assign rsp_valid = (state_q == S_RELEASE);
    assign rsp_err   = 1'b0;
`endif
    assign rsp_rdata = ((state_q == S_RELEASE) && !we_q) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized self-checking bench for sram_ctrl.
// Includes a pulse-protocol SRAM device and a word-array reference model.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [6:0]  sram_addr;
    logic        sram_addr_ready;
    logic        sram_read_pulse;
    logic        sram_write_pulse;
    logic [31:0] sram_datain;
    logic [31:0] sram_dataout = 32'd0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [128] = '{default: 32'd0};
    logic [31:0] ref_mem [128] = '{default: 32'd0};

    always #5 clk = ~clk;

    // SRAM device: write on write pulse, data out valid after read pulse.
    always @(posedge clk) begin
        if (sram_write_pulse) mem[sram_addr] <= sram_datain;
        if (sram_read_pulse) sram_dataout <= mem[sram_addr];
    end

    sram_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sram_addr(sram_addr), .sram_addr_ready(sram_addr_ready),
        .sram_read_pulse(sram_read_pulse),
        .sram_write_pulse(sram_write_pulse),
        .sram_datain(sram_datain), .sram_dataout(sram_dataout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h10;
        req_wdata = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (req_ready !== 1'b0) begin
                failures++;
                $display("FAIL rst_ready got=%0b exp=0", req_ready);
            end
            checks++;
            if ({sram_addr_ready, sram_read_pulse, sram_write_pulse,
                 rsp_valid, rsp_err} !== 5'b0) begin
                failures++;
                $display("FAIL rst_strobes got=%b exp=0",
                         {sram_addr_ready, sram_read_pulse,
                          sram_write_pulse, rsp_valid, rsp_err});
            end
            checks++;
            if (sram_addr !== 7'd0 || sram_datain !== 32'd0 ||
                rsp_rdata !== 32'd0) begin
                failures++;
                $display("FAIL rst_buses addr=%0h din=%0h rd=%0h exp=0",
                         sram_addr, sram_datain, rsp_rdata);
            end
        end
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_release_ready got=%0b exp=1", req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({sram_addr_ready, sram_read_pulse, sram_write_pulse,
                 rsp_valid} !== 4'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL idle_quiet got=%b rdy=%0b exp=0/1",
                         {sram_addr_ready, sram_read_pulse,
                          sram_write_pulse, rsp_valid}, req_ready);
            end
        end
    endtask

    // Per-cycle protocol check of one access against the five-phase rules.
    task automatic test_access(input logic we, input logic [31:0] addr,
                               input logic [31:0] data, input string nm);
        logic [6:0]  w;
        logic [31:0] exp_rd;
        logic [4:0]  exp_v;
        logic [4:0]  got_v;
        int wait_cyc;
        w = addr[8:2];
        exp_rd = we ? 32'd0 : ref_mem[w];
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 10) begin
            step();
            wait_cyc++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_timeout got=%0b exp=1", nm, req_ready);
        end
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = data;
        step();
        req_valid = 1'b0;
        req_wdata = $urandom;
        for (int k = 1; k <= 4; k++) begin
            exp_v = {k <= 3, !we && k == 2, we && k == 2, k == 4, 1'b0};
            got_v = {sram_addr_ready, sram_read_pulse, sram_write_pulse,
                     rsp_valid, rsp_err};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL %s c%0d ar/rp/wp/rv/re got=%b exp=%b",
                         nm, k, got_v, exp_v);
            end
            checks++;
            if (sram_addr !== w) begin
                failures++;
                $display("FAIL %s c%0d sram_addr got=%0h exp=%0h",
                         nm, k, sram_addr, w);
            end
            checks++;
            if (sram_datain !== (we ? data : 32'd0)) begin
                failures++;
                $display("FAIL %s c%0d datain got=%0h exp=%0h",
                         nm, k, sram_datain, we ? data : 32'd0);
            end
            checks++;
            if (rsp_rdata !== ((k == 4) ? exp_rd : 32'd0)) begin
                failures++;
                $display("FAIL %s c%0d rdata got=%0h exp=%0h",
                         nm, k, rsp_rdata, (k == 4) ? exp_rd : 32'd0);
            end
            if (k < 4) step();
        end
        if (we) ref_mem[w] = data;
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s after rdy=%0b rv=%0b exp=1/0",
                     nm, req_ready, rsp_valid);
        end
    endtask

    task automatic test_write_read();
        test_access(1'b1, 32'h10, 32'hDEADBEEF, "wr_0x10");
        test_access(1'b0, 32'h10, 32'h0, "rd_0x10");
        checks++;
        if (ref_mem[4] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL model_word4 got=%0h exp=deadbeef", ref_mem[4]);
        end
    endtask

    task automatic test_wrap();
`ifndef SRAM_CTRL_ADDR_CHECK_EN
        test_access(1'b1, 32'h200, 32'hA5A50001, "wrap_wr_0x200");
        test_access(1'b0, 32'h0, 32'h0, "wrap_rd_0x0");
        test_access(1'b0, 32'hFFFFFE03, 32'h0, "wrap_rd_hi");
        test_access(1'b1, 32'hFFFFFFFF, 32'h0BADF00D, "wrap_wr_top");
        test_access(1'b0, 32'h1FC, 32'h0, "wrap_rd_127");
`endif
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            we = ($urandom_range(0, 1) == 1);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
            a = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
`else
            a = $urandom;
`endif
            repeat ($urandom_range(0, 2)) step();
            test_access(we, a, $urandom, "rand");
        end
    endtask

    task automatic test_reset_abort();
        int rv_seen;
        test_access(1'b1, 32'h14, 32'h11112222, "pre_abort");
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h14;
        req_wdata = 32'h5555AAAA;
        step();
        req_valid = 1'b0;
        step();
        checks++;
        if (sram_write_pulse !== 1'b1) begin
            failures++;
            $display("FAIL abort_pulse got=%0b exp=1", sram_write_pulse);
        end
        rst = 1'b1;
        step();
        ref_mem[5] = 32'h5555AAAA;
        checks++;
        if ({sram_addr_ready, sram_read_pulse, sram_write_pulse,
             rsp_valid, rsp_err} !== 5'b0 || sram_addr !== 7'd0) begin
            failures++;
            $display("FAIL abort_strobes got=%b addr=%0h exp=0",
                     {sram_addr_ready, sram_read_pulse, sram_write_pulse,
                      rsp_valid, rsp_err}, sram_addr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_ready got=%0b exp=1", req_ready);
        end
        rv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid === 1'b1) rv_seen++;
            step();
        end
        checks++;
        if (rv_seen != 0) begin
            failures++;
            $display("FAIL abort_no_rsp got=%0d exp=0", rv_seen);
        end
        test_access(1'b0, 32'h14, 32'h0, "abort_readback");
    endtask

    task automatic test_back_to_back();
        int q[$];
        int issued;
        int got;
        int last;
        int cyc;
        int e;
        issued = 0;
        got = 0;
        last = -1;
        cyc = 0;
        req_we = 1'b1;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_valid = 1'b1;
        while (got < 256 && cyc < 1500) begin
            if (req_ready && req_valid) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 5) begin
                        failures++;
                        $display("FAIL b2b_spacing got=%0d exp=5",
                                 cyc - last);
                    end
                end
                last = cyc;
                q.push_back(req_we ? -1 : (issued % 128));
                if (req_we) ref_mem[issued % 128] = 32'(issued % 128);
                issued++;
            end
            if (rsp_valid === 1'b1) begin
                e = (q.size() > 0) ? q.pop_front() : -2;
                checks++;
                if (e == -2 || rsp_rdata !== ((e < 0) ? 32'd0 : 32'(e))) begin
                    failures++;
                    $display("FAIL b2b_rsp got=%0h exp=%0d", rsp_rdata, e);
                end
                got++;
            end
            checks++;
            if (sram_read_pulse === 1'b1 && sram_write_pulse === 1'b1) begin
                failures++;
                $display("FAIL b2b_overlap got=11 exp=not both");
            end
            step();
            cyc++;
            if (issued < 256) begin
                req_we = (issued < 128);
                req_addr = {23'd0, 7'(issued % 128), 2'b00};
                req_wdata = 32'(issued % 128);
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (got != 256) begin
            failures++;
            $display("FAIL b2b_timeout got=%0d exp=256", got);
        end
    endtask

    task automatic test_addr_err();
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        logic [31:0] bad [2];
        bad[0] = 32'h200;
        bad[1] = 32'h3;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1;
            req_we = 1'b0;
            req_addr = bad[i];
            step();
            req_valid = 1'b0;
            checks++;
            if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'd0) begin
                failures++;
                $display("FAIL err_rsp got=%b rd=%0h exp=11/0",
                         {rsp_valid, rsp_err}, rsp_rdata);
            end
            checks++;
            if ({sram_addr_ready, sram_read_pulse,
                 sram_write_pulse} !== 3'b0) begin
                failures++;
                $display("FAIL err_strobes got=%b exp=000",
                         {sram_addr_ready, sram_read_pulse,
                          sram_write_pulse});
            end
            step();
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
                sram_read_pulse !== 1'b0) begin
                failures++;
                $display("FAIL err_return rv=%0b rdy=%0b exp=0/1",
                         rsp_valid, req_ready);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_random();
        test_reset_abort();
        test_back_to_back();
        test_addr_err();
        test_access(1'b0, 32'h8, 32'h0, "final_rd");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
